sum_accumulator: RTL and testbench



---
 rtl/sum_accumulator.sv | 128 ++++++++++++
 tb/tb_sum_accumulator.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// Accumulates COUNT 5-bit adder results ({cout, sum}) into an ACC_W-bit total behind valid/ready handshakes.
// Optional macro ACC_SATURATE_EN: clamp the total at 2^ACC_W-1 on overflow instead of wrapping.
module sum_accumulator #(
   parameter int ACC_W = 8,
   parameter int COUNT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       sum_in,
   input  logic             cout_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             out_ovf,
   output logic [3:0]       out_cnt
);

   typedef enum logic [0:0] {ACCUM = 1'b0, OUTPUT = 1'b1} state_t;

   localparam logic [3:0]       LAST_CNT = 4'(COUNT - 1);
   localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};

   function automatic logic [ACC_W:0] widen_sample(input logic c, input logic [3:0] s);
      return {{(ACC_W-4){1'b0}}, c, s};
   endfunction

   state_t           state_r, state_s;
   logic [ACC_W-1:0] acc_r, acc_s, acc_add_s;
   logic [3:0]       cnt_r, cnt_s;
   logic             ovf_r, ovf_s;
   logic             valid_r, valid_s;
   logic [ACC_W:0]   sum_s;
   logic             carry_s;

   assign sum_s   = {1'b0, acc_r} + widen_sample(cout_in, sum_in);
   assign carry_s = sum_s[ACC_W];

   // Value the accumulator takes on an accepted sample
   always_comb begin
      acc_add_s = sum_s[ACC_W-1:0];
`ifdef ACC_SATURATE_EN
      if (carry_s || ovf_r) begin
         acc_add_s = ACC_MAX;
      end else begin
         acc_add_s = sum_s[ACC_W-1:0];
      end
`endif
   end

   // Next-state and next-register values; clear outranks both handshakes
   always_comb begin
      state_s = state_r;
      acc_s   = acc_r;
      cnt_s   = cnt_r;
      ovf_s   = ovf_r;
      valid_s = valid_r;
      if (clear) begin
         state_s = ACCUM;
         acc_s   = '0;
         cnt_s   = 4'd0;
         ovf_s   = 1'b0;
         valid_s = 1'b0;
      end else begin
         case (state_r)
            ACCUM: begin
               if (in_valid) begin
                  acc_s = acc_add_s;
                  cnt_s = cnt_r + 4'd1;
                  ovf_s = ovf_r | carry_s;
                  if (cnt_r == LAST_CNT) begin
                     state_s = OUTPUT;
                     valid_s = 1'b1;
                  end else begin
                     state_s = ACCUM;
                  end
               end else begin
                  state_s = ACCUM;
               end
            end
            OUTPUT: begin
               if (out_ready) begin
                  state_s = ACCUM;
                  acc_s   = '0;
                  cnt_s   = 4'd0;
                  ovf_s   = 1'b0;
                  valid_s = 1'b0;
               end else begin
                  state_s = OUTPUT;
               end
            end
            default: begin
               state_s = ACCUM;
               acc_s   = '0;
               cnt_s   = 4'd0;
               ovf_s   = 1'b0;
               valid_s = 1'b0;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ACCUM;
         acc_r   <= '0;
         cnt_r   <= 4'd0;
         ovf_r   <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         state_r <= state_s;
         acc_r   <= acc_s;
         cnt_r   <= cnt_s;
         ovf_r   <= ovf_s;
         valid_r <= valid_s;
      end
   end

   assign in_ready  = rst_n & (state_r == ACCUM);
   assign out_valid = valid_r;
   assign out_data  = acc_r;
   assign out_ovf   = ovf_r;
   assign out_cnt   = cnt_r;

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench: directed vector table, overflow sequence and random stimulus against a batch-total model.
// Two instances (ACC_W=8 and ACC_W=6) share the same stimulus.
module tb_sum_accumulator;

   localparam int COUNT = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, cout_in = 1'b0, out_ready = 1'b0;
   logic [3:0] sum_in = 4'd0;

   logic       in_ready_a, out_valid_a, out_ovf_a;
   logic [7:0] out_data_a;
   logic [3:0] out_cnt_a;
   logic       in_ready_b, out_valid_b, out_ovf_b;
   logic [5:0] out_data_b;
   logic [3:0] out_cnt_b;

   int n_cmp = 0;
   int n_err = 0;

   bit m_out   = 1'b0;
   int m_cnt   = 0;
   int m_total = 0;

   always #5 clk = ~clk;

   sum_accumulator #(.ACC_W(8), .COUNT(COUNT)) dut_a (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_a),
      .sum_in(sum_in), .cout_in(cout_in), .out_valid(out_valid_a), .out_ready(out_ready),
      .out_data(out_data_a), .out_ovf(out_ovf_a), .out_cnt(out_cnt_a));

   sum_accumulator #(.ACC_W(6), .COUNT(COUNT)) dut_b (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_b),
      .sum_in(sum_in), .cout_in(cout_in), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_data(out_data_b), .out_ovf(out_ovf_b), .out_cnt(out_cnt_b));

   typedef struct {
      logic r, cl, iv;
      logic [3:0] s;
      logic c, ordy;
      logic ev, er;
      logic [7:0] ed;
      logic eo;
      logic [3:0] ec;
   } vec_t;

   vec_t tbl[$];

   function automatic int exp_data(input int total, input int w);
`ifdef ACC_SATURATE_EN
      return (total >= (1 << w)) ? (1 << w) - 1 : total;
`else
      return total % (1 << w);
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic r, cl, iv, input logic [3:0] s, input logic c, ordy,
                      input logic ev, er, input logic [7:0] ed, input logic eo, input logic [3:0] ec);
      vec_t v;
      v.r = r; v.cl = cl; v.iv = iv; v.s = s; v.c = c; v.ordy = ordy;
      v.ev = ev; v.er = er; v.ed = ed; v.eo = eo; v.ec = ec;
      tbl.push_back(v);
   endtask

   // Drive one cycle, advance the batch model, and compare both instances after the edge
   task automatic apply(input logic r, cl, iv, input logic [3:0] s, input logic c, ordy);
      rst_n = r; clear = cl; in_valid = iv; sum_in = s; cout_in = c; out_ready = ordy;
      if (!r || cl) begin
         m_out = 1'b0; m_cnt = 0; m_total = 0;
      end else if (m_out) begin
         if (ordy) begin
            m_out = 1'b0; m_cnt = 0; m_total = 0;
         end
      end else if (iv) begin
         m_total += int'({c, s});
         m_cnt++;
         if (m_cnt == COUNT) m_out = 1'b1;
      end
      @(posedge clk);
      #1;
      chk("a.valid", out_valid_a, m_out);
      chk("a.ready", in_ready_a, r && !m_out);
      chk("a.cnt",   out_cnt_a, m_cnt);
      chk("a.data",  out_data_a, exp_data(m_total, 8));
      chk("a.ovf",   out_ovf_a, m_total >= 256);
      chk("b.valid", out_valid_b, m_out);
      chk("b.ready", in_ready_b, r && !m_out);
      chk("b.cnt",   out_cnt_b, m_cnt);
      chk("b.data",  out_data_b, exp_data(m_total, 6));
      chk("b.ovf",   out_ovf_b, m_total >= 64);
   endtask

   initial begin
      // reset, basic batch 3,5,7,9 then one-cycle output transfer
      add(0,0,0,0,0,0, 0,0,0,0,0);
      add(1,0,1,3,0,1, 0,1,3,0,1);  add(1,0,1,5,0,1, 0,1,8,0,2);
      add(1,0,1,7,0,1, 0,1,15,0,3); add(1,0,1,9,0,1, 1,0,24,0,4);
      add(1,0,1,1,0,1, 0,1,0,0,0);
      // carry weighting: 31 x 4
      add(1,0,1,15,1,1, 0,1,31,0,1); add(1,0,1,15,1,1, 0,1,62,0,2);
      add(1,0,1,15,1,1, 0,1,93,0,3); add(1,0,1,15,1,1, 1,0,124,0,4);
      add(1,0,0,0,0,1, 0,1,0,0,0);
      // backpressure
      add(1,0,1,3,0,0, 0,1,3,0,1);  add(1,0,1,5,0,0, 0,1,8,0,2);
      add(1,0,1,7,0,0, 0,1,15,0,3); add(1,0,1,9,0,0, 1,0,24,0,4);
      for (int i = 0; i < 5; i++) add(1,0,1,1,0,0, 1,0,24,0,4);
      add(1,0,1,1,0,1, 0,1,0,0,0);
      add(1,0,1,1,0,1, 0,1,1,0,1); add(1,0,1,1,0,1, 0,1,2,0,2);
      add(1,0,1,1,0,1, 0,1,3,0,3); add(1,0,1,1,0,0, 1,0,4,0,4);
      add(1,0,0,0,0,1, 0,1,0,0,0);
      // clear mid-batch with a concurrent in_valid
      add(1,0,1,2,0,1, 0,1,2,0,1); add(1,0,1,2,0,1, 0,1,4,0,2);
      add(1,1,1,2,0,1, 0,1,0,0,0);
      add(1,0,1,1,0,0, 0,1,1,0,1); add(1,0,1,1,0,0, 0,1,2,0,2);
      add(1,0,1,1,0,0, 0,1,3,0,3); add(1,0,1,1,0,0, 1,0,4,0,4);
      add(1,0,0,0,0,0, 1,0,4,0,4);
      // clear discards a pending total
      add(1,1,0,0,0,0, 0,1,0,0,0);
      add(1,0,1,1,0,0, 0,1,1,0,1); add(1,0,1,1,0,0, 0,1,2,0,2);
      add(1,0,1,1,0,0, 0,1,3,0,3); add(1,0,1,1,0,0, 1,0,4,0,4);
      // reset while in OUTPUT, then release
      add(0,0,1,1,0,1, 0,0,0,0,0);
      add(1,0,0,0,0,1, 0,1,0,0,0);

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i].r, tbl[i].cl, tbl[i].iv, tbl[i].s, tbl[i].c, tbl[i].ordy);
         chk($sformatf("tbl[%0d].valid", i), out_valid_a, tbl[i].ev);
         chk($sformatf("tbl[%0d].ready", i), in_ready_a, tbl[i].er);
         chk($sformatf("tbl[%0d].data", i),  out_data_a, tbl[i].ed);
         chk($sformatf("tbl[%0d].ovf", i),   out_ovf_a, tbl[i].eo);
         chk($sformatf("tbl[%0d].cnt", i),   out_cnt_a, tbl[i].ec);
      end

      // overflow on the 6-bit instance: four samples of 31
      apply(0,0,0,4'd0,0,0);
      for (int i = 0; i < 4; i++) begin
         apply(1,0,1,4'd15,1,0);
         if (i == 2) chk("ovf6.sticky_mid", out_ovf_b, 32'd1);
      end
`ifdef ACC_SATURATE_EN
      chk("ovf6.data", out_data_b, 32'd63);
`else
      chk("ovf6.data", out_data_b, 32'd60);
`endif
      chk("ovf6.flag", out_ovf_b, 32'd1);
      chk("ovf8.data", out_data_a, 32'd124);
      chk("ovf8.flag", out_ovf_a, 32'd0);
      apply(1,0,0,4'd0,0,1);
      chk("ovf6.cleared", out_ovf_b, 32'd0);
      for (int i = 0; i < 4; i++) apply(1,0,1,4'd1,0,0);
      chk("ovf6.next_data", out_data_b, 32'd4);
      chk("ovf6.next_flag", out_ovf_b, 32'd0);
      chk("ovf6.next_valid", out_valid_b, 32'd1);
      apply(1,0,0,4'd0,0,1);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         apply($urandom_range(63, 0) != 0, $urandom_range(15, 0) == 0,
               $urandom_range(3, 0) != 0, 4'($urandom), 1'($urandom), 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
